// File: rtl/xadc_monitor_if.sv
// XADC-side and result-side signals of xadc_monitor; master is the monitor itself,
// slave is the XADC wrapper / display side. No flow control: every output is a strobe or level.
interface xadc_monitor_if;
   logic        trigger;
   logic        busy_in;
   logic        eoc_in;
   logic        drp_den;
   logic        drp_dwe;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_do;
   logic        drp_drdy;
   logic        res_valid;
   logic [2:0]  res_chan;
   logic [11:0] res_raw;
   logic [15:0] res_val;
   logic [19:0] res_bcd;
   logic        res_clamp;
   logic        sweep_done;
   logic        drp_err;

   modport master (
      input  trigger, busy_in, eoc_in, drp_do, drp_drdy,
      output drp_den, drp_dwe, drp_daddr, res_valid, res_chan, res_raw,
             res_val, res_bcd, res_clamp, sweep_done, drp_err
   );

   modport slave (
      output trigger, busy_in, eoc_in, drp_do, drp_drdy,
      input  drp_den, drp_dwe, drp_daddr, res_valid, res_chan, res_raw,
             res_val, res_bcd, res_clamp, sweep_done, drp_err
   );
endinterface

// File: rtl/xadc_monitor.sv
// XADC DRP sweep reader: after each eoc reads NCHAN registers, converts to 0.01 degC or mV and BCD.
// Latency: res_valid 21 cycles after drp_drdy; no backpressure, results are single-cycle strobes.
module xadc_monitor #(
   parameter int                 NCHAN     = 4,
   parameter logic [7*NCHAN-1:0] ADDRS     = {7'h06, 7'h02, 7'h01, 7'h00},
   parameter logic [7:0]         TEMP_MASK = 8'b0000_0001,
   parameter int                 SETTLE    = 31,
   parameter int                 TMO       = 63
) (
   input  logic           clk,
   input  logic           rst,
   xadc_monitor_if.master bus
);

   localparam int CMAX = (SETTLE > TMO) ? SETTLE : TMO;
   localparam int CW   = $clog2(((CMAX > 16) ? CMAX : 16) + 1);

   localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
   localparam logic [CW-1:0] CONV_LAST = CW'(2);
   localparam logic [CW-1:0] BCD_LAST  = CW'(16);
   localparam logic [2:0]    LAST_CH   = 3'(NCHAN - 1);

   localparam logic [27:0] TEMP_K     = 28'd50397;
   localparam logic [27:0] SUPPLY_K   = 28'd3000;
   localparam logic [16:0] KELVIN_OFS = 17'd27315;

   typedef enum logic [2:0] {
      S_SETTLE, S_WAIT_EOC, S_READ, S_WAIT_RDY, S_CONV, S_BCD, S_EMIT, S_NEXT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    ch_q, ch_d;

   logic [11:0] raw_q, raw_d;
   logic [27:0] p_q, p_d;
   logic [16:0] q_q, q_d;
   logic [15:0] val_q, val_d;
   logic        clamp_q, clamp_d;
   logic [15:0] bin_q, bin_d;
   logic [19:0] bcd_q, bcd_d;
   logic        err_q, err_d;

   logic [2:0]  res_chan_q, res_chan_d;
   logic [11:0] res_raw_q, res_raw_d;
   logic [15:0] res_val_q, res_val_d;
   logic [19:0] res_bcd_q, res_bcd_d;
   logic        res_clamp_q, res_clamp_d;

   logic        restart;
   logic        is_temp;
   logic [16:0] t;
   logic [19:0] adj;
   logic        unused_ok;

   // trigger restarts exactly like rst, including the sticky error flag
   assign restart   = rst | bus.trigger;
   assign is_temp   = TEMP_MASK[ch_q];
   assign unused_ok = ^{bus.drp_do[3:0], adj[19]};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (restart) begin
         state_q <= S_SETTLE;
         cnt_q   <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      case (state_q)
         S_SETTLE: begin
            if (cnt_q == SETTLE_C) begin
               if (!bus.busy_in) begin
                  state_d = S_WAIT_EOC;
                  cnt_d   = '0;
                  ch_d    = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_EOC: begin
            if (bus.eoc_in) state_d = S_READ;
         end
         S_READ: begin
            state_d = S_WAIT_RDY;
            cnt_d   = '0;
         end
         S_WAIT_RDY: begin
            if (bus.drp_drdy) begin
               state_d = S_CONV;
               cnt_d   = '0;
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_NEXT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CONV: begin
            if (cnt_q == CONV_LAST) begin
               state_d = S_BCD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BCD: begin
            if (cnt_q == BCD_LAST) begin
               state_d = S_EMIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_EMIT: state_d = S_NEXT;
         S_NEXT: begin
            if (ch_q == LAST_CH) begin
               state_d = S_WAIT_EOC;
               ch_d    = '0;
            end else begin
               state_d = S_READ;
               ch_d    = ch_q + 3'd1;
            end
         end
         default: state_d = S_SETTLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.drp_den    = 1'b0;
      bus.drp_daddr  = '0;
      bus.res_valid  = 1'b0;
      bus.sweep_done = 1'b0;
      // a restart in flight suppresses every strobe of the aborted sweep
      if (!restart) begin
         case (state_q)
            S_READ: begin
               bus.drp_den   = 1'b1;
               bus.drp_daddr = ADDRS[7 * int'(ch_q) +: 7];
            end
            S_EMIT:  bus.res_valid  = 1'b1;
            S_NEXT:  bus.sweep_done = (ch_q == LAST_CH);
            default: ;
         endcase
      end
   end

   assign bus.drp_dwe   = 1'b0;
   assign bus.res_chan  = res_chan_q;
   assign bus.res_raw   = res_raw_q;
   assign bus.res_val   = res_val_q;
   assign bus.res_bcd   = res_bcd_q;
   assign bus.res_clamp = res_clamp_q;
   assign bus.drp_err   = err_q;

   // ---------------- datapath ----------------
   always_comb begin
      raw_d = raw_q;
      err_d = err_q;
      if (state_q == S_WAIT_RDY) begin
         if (bus.drp_drdy)            raw_d = bus.drp_do[15:4];
         else if (cnt_q == TMO_LAST)  err_d = 1'b1;
      end

      // free-running 3-stage transfer; raw_q and ch_q are stable throughout CONV
      p_d = {16'd0, raw_q} * (is_temp ? TEMP_K : SUPPLY_K);
      q_d = is_temp ? ({1'b0, p_q[27:12]} + {16'd0, p_q[11]})
                    : ({5'd0, p_q[23:12]} + {16'd0, p_q[11]});
      t   = q_q - KELVIN_OFS;
      if (!is_temp) begin
         val_d   = q_q[15:0];
         clamp_d = 1'b0;
      end else if (t[16]) begin
         val_d   = '0;
         clamp_d = 1'b1;
      end else begin
         val_d   = t[15:0];
         clamp_d = 1'b0;
      end

      adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end

      bin_d = bin_q;
      bcd_d = bcd_q;
      if (state_q == S_BCD) begin
         if (cnt_q == '0) begin
            bin_d = val_q;
            bcd_d = '0;
         end else begin
            bcd_d = {adj[18:0], bin_q[15]};
            bin_d = {bin_q[14:0], 1'b0};
         end
      end

      res_chan_d  = res_chan_q;
      res_raw_d   = res_raw_q;
      res_val_d   = res_val_q;
      res_bcd_d   = res_bcd_q;
      res_clamp_d = res_clamp_q;
      if (state_q == S_BCD && cnt_q == BCD_LAST) begin
         res_chan_d  = ch_q;
         res_raw_d   = raw_q;
         res_val_d   = val_q;
         res_bcd_d   = bcd_d;
         res_clamp_d = clamp_q;
      end
   end

   always_ff @(posedge clk) begin
      if (restart) begin
         raw_q       <= '0;
         p_q         <= '0;
         q_q         <= '0;
         val_q       <= '0;
         clamp_q     <= 1'b0;
         bin_q       <= '0;
         bcd_q       <= '0;
         err_q       <= 1'b0;
         res_chan_q  <= '0;
         res_raw_q   <= '0;
         res_val_q   <= '0;
         res_bcd_q   <= '0;
         res_clamp_q <= 1'b0;
      end else begin
         raw_q       <= raw_d;
         p_q         <= p_d;
         q_q         <= q_d;
         val_q       <= val_d;
         clamp_q     <= clamp_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         err_q       <= err_d;
         res_chan_q  <= res_chan_d;
         res_raw_q   <= res_raw_d;
         res_val_q   <= res_val_d;
         res_bcd_q   <= res_bcd_d;
         res_clamp_q <= res_clamp_d;
      end
   end

endmodule
